// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ibuf_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush; head is read straight from storage.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wp, rp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rdata = mem[rp];
endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: tracks in-flight requests, drops stale responses
// after a redirect and buffers returned words for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]   outs, outs_nxt, discard, buf_cnt, buf_nxt, live;
  logic [CW:0]     sum_nxt;
  logic            req_q, hs, rsp, keep, pop;
  ibuf_t           head, wentry;

  assign hs   = req_q & imem_gnt;
  // A response with nothing outstanding is spurious and ignored outright.
  assign rsp  = imem_rvalid & (outs != '0);
  // live counts non-stale requests still in the address queue.
  assign keep = rsp & (discard == '0) & (live != '0) & ~redirect_valid;
  assign pop  = (buf_cnt != '0) & instr_ready & ~redirect_valid;

  assign outs_nxt = outs + CW'(hs) - CW'(rsp);
  assign buf_nxt  = redirect_valid ? '0 : buf_cnt + CW'(keep) - CW'(pop);
  assign sum_nxt  = {1'b0, outs_nxt} + {1'b0, buf_nxt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      outs     <= '0;
      discard  <= '0;
      req_q    <= 1'b0;
    end else begin
      outs  <= outs_nxt;
      req_q <= sum_nxt < (CW+1)'(DEPTH);
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        discard  <= outs_nxt;
      end else begin
        if (hs) fetch_pc <= fetch_pc + PC_STEP;
        if (rsp && discard != '0) discard <= discard - 1'b1;
      end
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addrq (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(hs & ~redirect_valid), .wdata(fetch_pc), .pop(keep),
    .rdata(rsp_pc), .count(live)
  );

  assign wentry = '{instr: imem_rdata, pc: rsp_pc};

  fetch_fifo #(.WIDTH($bits(ibuf_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(keep), .wdata(wentry), .pop(pop),
    .rdata(head), .count(buf_cnt)
  );

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc;
  assign instr_valid = buf_cnt != '0;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a stream-level reference
// (after reset/redirect to T, decode must see T, T+4, ... with matching words).
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0, rst = 1'b0;
  logic redirect_valid = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] memq[$];
  logic [31:0] exp_fetch, exp_pc, prev_addr, hold_addr, force_target, last_hs;
  int gnt_mode, rv_mode, rdy_mode, hs_cnt, edges, first_iv;
  bit rnd_redir, spur, force_redir, prev_pend, wrap_ok;

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    exp_fetch = RPC; exp_pc = RPC;
    prev_pend = 0; hs_cnt = 0; edges = 0; first_iv = -1; last_hs = 32'h1;
  endtask

  // One cycle: sample at negedge, check, drive inputs, advance the model.
  task automatic tick();
    logic r, v, g, rv, rdy, redir, hsx;
    logic [31:0] a, ins, ipc, tgt, rd;
    r = imem_req; a = imem_addr; v = instr_valid; ins = instr; ipc = instr_pc;
    if (prev_pend) begin
      chk("req_hold", 32'(r), 32'd1);
      chk("addr_hold", a, prev_addr);
    end
    if (v) begin
      chk("instr_pc", ipc, exp_pc);
      chk("instr_word", ins, mk(exp_pc));
      if (first_iv < 0) first_iv = edges;
    end
    redir = force_redir || (rnd_redir && $urandom_range(0, 29) == 0);
    if (force_redir) tgt = force_target;
    else if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else tgt = $urandom;
    case (gnt_mode)
      0: g = 1'($urandom_range(0, 1));
      1: g = (a != hold_addr);
      default: g = 1'b0;
    endcase
    case (rdy_mode)
      0: rdy = 1'($urandom_range(0, 1));
      1: rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
    rv = 1'b0; rd = $urandom;
    if (memq.size() > 0 && (rv_mode == 1 || (rv_mode == 0 && $urandom_range(0, 1) == 1))) begin
      rv = 1'b1; rd = mk(memq.pop_front());
    end else if (spur && memq.size() == 0 && $urandom_range(0, 9) == 0) begin
      rv = 1'b1;
    end
    hsx = r && g;
    if (hsx) begin
      chk("fetch_addr", a, exp_fetch);
      memq.push_back(a);
      chk("inflight_bound", 32'(memq.size() <= DEPTH), 32'd1);
      hs_cnt++;
      if (a == 32'h0 && last_hs == 32'hFFFF_FFFC) wrap_ok = 1;
      last_hs = a;
    end
    if (redir) begin
      exp_fetch = {tgt[31:2], 2'b00};
      exp_pc = exp_fetch;
    end else begin
      if (hsx) exp_fetch = exp_fetch + 32'd4;
      if (v && rdy) exp_pc = exp_pc + 32'd4;
    end
    prev_pend = r && !g && !redir;
    prev_addr = a;
    redirect_valid = redir; redirect_pc = tgt; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; instr_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1;
  endtask

  task automatic set_modes(input int g, input int rv, input int rdy);
    gnt_mode = g; rv_mode = rv; rdy_mode = rdy;
  endtask

  initial begin
    rnd_redir = 0; spur = 0; force_redir = 0; wrap_ok = 0;
    hold_addr = 32'h1; force_target = '0;
    model_reset();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, RPC);

    // Reset release, grant tied high, single-cycle responses
    model_reset();
    rst = 1;
    set_modes(1, 1, 1);
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RPC);
    repeat (7) tick();
    chk("first_iv_edge", 32'(first_iv), 32'd3);
    chk("three_grants", 32'(hs_cnt >= 3), 32'd1);

    // Decode stalled: requests stop after DEPTH grants, then drain in order
    do_reset();
    set_modes(1, 1, 2);
    repeat (8) tick();
    chk("stall_grants", 32'(hs_cnt), 32'(DEPTH));
    chk("stall_req_low", 32'(imem_req), 32'd0);
    set_modes(1, 1, 1);
    repeat (8) tick();
    chk("resume_grants", 32'(hs_cnt > DEPTH), 32'd1);

    // Redirect with two requests outstanding
    do_reset();
    set_modes(1, 2, 1);
    repeat (4) tick();
    chk("outstanding_two", 32'(memq.size()), 32'd2);
    force_redir = 1; force_target = 32'h0000_0103;
    tick();
    force_redir = 0;
    chk("redir_addr", imem_addr, 32'h0000_0100);
    first_iv = -1;
    set_modes(1, 1, 1);
    repeat (10) tick();
    chk("redir_delivered", 32'(first_iv >= 0), 32'd1);

    // Grant withheld at 0x8 for many cycles, then granted
    do_reset();
    hold_addr = 32'h8;
    set_modes(1, 1, 1);
    repeat (12) tick();
    chk("held_req", 32'(imem_req), 32'd1);
    chk("held_addr", imem_addr, 32'h8);
    hold_addr = 32'h1;
    tick();
    chk("after_hold_addr", imem_addr, 32'hC);

    // Wrap from 0xFFFF_FFFC to 0 (unaligned redirect target)
    force_redir = 1; force_target = 32'hFFFF_FFFF;
    tick();
    force_redir = 0;
    repeat (10) tick();
    chk("pc_wrap", 32'(wrap_ok), 32'd1);

    // Reset mid-burst with responses pending
    set_modes(1, 2, 0);
    repeat (3) tick();
    chk("pending_before_rst", 32'(memq.size() > 0), 32'd1);
    idle_inputs();
    #2 rst = 0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_iv", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_ipc", instr_pc, 32'd0);
    chk("midrst_addr", imem_addr, RPC);
    @(negedge clk);
    model_reset();
    rst = 1;
    set_modes(1, 1, 1);
    tick();
    chk("rerst_req", 32'(imem_req), 32'd1);
    chk("rerst_addr", imem_addr, RPC);
    chk("rerst_no_stale", 32'(instr_valid), 32'd0);
    repeat (6) tick();

    // Random traffic with redirects and spurious responses
    set_modes(0, 0, 0);
    rnd_redir = 1; spur = 1;
    repeat (3000) tick();
    rnd_redir = 0; spur = 0;
    set_modes(1, 1, 1);
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, which is the instruction buffer depth and maximum in-flight count (power of two, 2..8).
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port redirect_valid  in  1  branch/jump redirect strobe.
REQ-006 The block SHALL have port redirect_pc  in  32  redirect target.
REQ-007 The block SHALL have port imem_req  out  1  instruction memory request.
REQ-008 The block SHALL have port imem_addr  out  32  request address, word aligned.
REQ-009 The block SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-010 The block SHALL have port imem_rvalid  in  1  read data valid; responses return in order.
REQ-011 The block SHALL have port imem_rdata  in  32  instruction word.
REQ-012 The block SHALL have port instr_valid  out  1  buffered instruction available to decode.
REQ-013 The block SHALL have port instr_ready  in  1  decode accepts the instruction.
REQ-014 The block SHALL have port instr  out  32  instruction word.
REQ-015 The block SHALL have port instr_pc  out  32  address of instr.

Function
REQ-016 fetch_pc SHALL advance by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) on each handshake, i.e. each cycle with imem_req && imem_gnt.
REQ-017 imem_req SHALL assert when (outstanding + buffer count) < DEPTH, and imem_addr SHALL equal fetch_pc.
REQ-018 Once raised, imem_req and imem_addr SHALL hold stable until imem_gnt, except on redirect.
REQ-019 The outstanding count SHALL increment on each grant and decrement on each imem_rvalid; a simultaneous grant and rvalid SHALL leave it unchanged.
REQ-020 On imem_rvalid with no discards pending, the block SHALL write {imem_rdata, response pc} into the buffer; the response pc is tracked per in-flight request in a DEPTH-entry address queue.
REQ-021 instr_valid SHALL be driven from the buffer (not empty), with no combinational path from imem_rvalid to instr_valid/instr.
REQ-022 Minimum latency SHALL be: rvalid in cycle N -> instr_valid in cycle N+1.
REQ-023 The block SHALL pop the buffer on instr_valid && instr_ready.
REQ-024 A push and a pop in the same cycle SHALL be legal when the buffer is full; overflow is prevented by REQ-017.
REQ-025 On redirect_valid, in the same cycle the block SHALL:
  - set fetch_pc <= {redirect_pc[31:2], 2'b00};
  - flush the buffer (instr_valid = 0 the next cycle);
  - deassert imem_req for that cycle;
  - set discard count <= outstanding after this cycle's grant/rvalid updates.
REQ-026 While discard > 0, each imem_rvalid SHALL decrement discard and be dropped.
REQ-027 Fetching SHALL resume at the new pc the cycle after redirect, even with discards pending.
REQ-028 Redirect SHALL take priority over pop, push and grant in the same cycle.
REQ-029 A grant coinciding with redirect SHALL count as outstanding and be discarded.
REQ-030 Back-to-back redirects SHALL each fully reapply REQ-025; the last target wins.
REQ-031 Spurious imem_rvalid with outstanding = 0 SHALL be ignored, and the counters SHALL saturate at 0.

Reset
REQ-032 While rst = 0, the block SHALL hold fetch_pc = RESET_PC, outstanding = 0, discard = 0, buffer empty, imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-033 Reset assertion mid-transaction SHALL abandon all in-flight requests immediately.
REQ-034 After reset, the first imem_req SHALL rise on the first clk edge following deassertion.

Structure
REQ-035 A shared package SHALL hold XLEN = 32, the NOP encoding 32'h0000_0013, and the word-align helper constant PC_STEP = 4.
REQ-036 The buffer SHALL be one sub-module, fetch_fifo (parameterised width/depth, synchronous flush input), used for both the instruction buffer and the address queue.

Verification
REQ-037 Reset release with gnt tied 1 and 1-cycle rvalid SHALL produce imem_addr 0,4,8; instr_valid first high 3 cycles after release with instr_pc = 0.
REQ-038 instr_ready held 0 with DEPTH = 2 SHALL stop imem_req after 2 grants; asserting ready SHALL pop the entries in order (pc 0, 4) and resume requests.
REQ-039 Redirect to 32'h0000_0103 with 2 requests outstanding SHALL issue next imem_addr 32'h0000_0100, drop both stale responses, and make the first instr_pc after the redirect 32'h100.
REQ-040 imem_gnt held low for 5 cycles SHALL keep imem_req and imem_addr stable at 32'h8; on the 6th-cycle grant, fetch_pc SHALL become 32'hC.
REQ-041 fetch_pc = 32'hFFFF_FFFC with a grant SHALL make the next imem_addr 32'h0000_0000.
REQ-042 Asserting rst low mid-burst with rvalid pending SHALL clear all outputs immediately; after release, fetching SHALL restart at RESET_PC with no stale instr_valid.
